// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset controller.
//   - FSM state encodings (also exported on mc_ctrl.state for debug)
//   - opcode / funct constants of the supported instruction subset
//   - select encodings for npcop, alu_op, ext_op, rf_wsel, wd_sel
//   - one-hot instruction class produced by mc_decode
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BEQ  = 2'b01;
   localparam logic [1:0] NPC_J    = 2'b10;
   localparam logic [1:0] NPC_JR   = 2'b11;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;
   localparam logic [1:0] ALU_LUI  = 2'b11;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HI   = 2'b10;

   localparam logic [1:0] WSEL_RT  = 2'b00;
   localparam logic [1:0] WSEL_RD  = 2'b01;
   localparam logic [1:0] WSEL_RA  = 2'b10;

   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_MEM   = 2'b01;
   localparam logic [1:0] WD_PC4   = 2'b10;

   // Exactly one field is set for any (op, funct).
   typedef struct packed {
      logic rtype_alu;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic jr;
      logic illegal;
   } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational instruction classifier.
//   op    in  6 : IR[31:26]
//   funct in  6 : IR[5:0] (only meaningful for R-type)
//   ic    out   : one-hot instruction class
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_t    ic
);

   always_comb begin
      ic = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU: ic.rtype_alu = 1'b1;
               FN_JR:            ic.jr        = 1'b1;
               default:          ic.illegal   = 1'b1;
            endcase
         end
         OP_ORI:  ic.ori     = 1'b1;
         OP_LUI:  ic.lui     = 1'b1;
         OP_LW:   ic.lw      = 1'b1;
         OP_SW:   ic.sw      = 1'b1;
         OP_BEQ:  ic.beq     = 1'b1;
         OP_J:    ic.j       = 1'b1;
         OP_JAL:  ic.jal     = 1'b1;
         default: ic.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM (FETCH/DECODE/EXE/MEM/WB).
//   clk, rst         : clock, synchronous active-high reset
//   op, funct        : instruction fields from IR
//   zero             : ALU zero flag (consumed by the NPC unit, not here)
//   mem_rdy          : memory access completes in a cycle with mem_rdy=1
//   pc_we, npcop     : PC load and next-PC select (one pc_we per instruction)
//   ir_we            : IR load
//   rf_we, rf_wsel, wd_sel : register file write enable / address / data selects
//   alu_op, alu_bsrc, ext_op : ALU and extender selects
//   dm_we            : data memory write
//   illegal          : one-cycle pulse on unsupported op/funct
//   state            : current FSM state for debug
module mc_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_rdy,
   output logic       pc_we,
   output logic [1:0] npcop,
   output logic       ir_we,
   output logic       rf_we,
   output logic [1:0] rf_wsel,
   output logic [1:0] wd_sel,
   output logic [1:0] alu_op,
   output logic       alu_bsrc,
   output logic [1:0] ext_op,
   output logic       dm_we,
   output logic       illegal,
   output logic [2:0] state
);

   state_t  state_q, state_d;
   iclass_t ic;

   // Branch resolution happens in the NPC unit; zero is a pass-through here.
   logic unused_zero;
   assign unused_zero = zero;

   mc_decode u_decode (
      .op    (op),
      .funct (funct),
      .ic    (ic)
   );

   // ALU/extender selects for the current instruction. Driven from EXE
   // through WB so the datapath result stays stable until write-back.
   logic [1:0] alu_op_i;
   logic       alu_bsrc_i;
   logic [1:0] ext_op_i;

   always_comb begin
      alu_op_i   = ALU_ADD;
      alu_bsrc_i = 1'b0;
      ext_op_i   = EXT_ZERO;
      if (ic.rtype_alu) begin
         alu_op_i = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end else if (ic.ori) begin
         alu_op_i   = ALU_OR;
         alu_bsrc_i = 1'b1;
      end else if (ic.lui) begin
         alu_op_i   = ALU_LUI;
         alu_bsrc_i = 1'b1;
         ext_op_i   = EXT_HI;
      end else if (ic.lw || ic.sw) begin
         alu_bsrc_i = 1'b1;
         ext_op_i   = EXT_SIGN;
      end else if (ic.beq) begin
         alu_op_i = ALU_SUB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = S_FETCH;
      pc_we    = 1'b0;
      npcop    = NPC_PC4;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      rf_wsel  = WSEL_RT;
      wd_sel   = WD_ALU;
      alu_op   = ALU_ADD;
      alu_bsrc = 1'b0;
      ext_op   = EXT_ZERO;
      dm_we    = 1'b0;
      illegal  = 1'b0;
      // All outputs are forced low while rst is high so an in-flight
      // access is dropped rather than committed.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               ir_we   = mem_rdy;
               state_d = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               state_d = S_EXE;
               if (ic.j || ic.jal) begin
                  pc_we   = 1'b1;
                  npcop   = NPC_J;
                  state_d = S_FETCH;
                  if (ic.jal) begin
                     rf_we   = 1'b1;
                     rf_wsel = WSEL_RA;
                     wd_sel  = WD_PC4;
                  end
               end else if (ic.jr) begin
                  pc_we   = 1'b1;
                  npcop   = NPC_JR;
                  state_d = S_FETCH;
               end else if (ic.illegal) begin
                  illegal = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_EXE: begin
               alu_op   = alu_op_i;
               alu_bsrc = alu_bsrc_i;
               ext_op   = ext_op_i;
               if (ic.beq) begin
                  pc_we   = 1'b1;
                  npcop   = NPC_BEQ;
                  state_d = S_FETCH;
               end else if (ic.lw || ic.sw) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               alu_op   = alu_op_i;
               alu_bsrc = alu_bsrc_i;
               ext_op   = ext_op_i;
               if (ic.sw) begin
                  dm_we = mem_rdy;
                  pc_we = mem_rdy;
               end
               if (!mem_rdy)   state_d = S_MEM;
               else if (ic.lw) state_d = S_WB;
               else            state_d = S_FETCH;
            end
            S_WB: begin
               alu_op   = alu_op_i;
               alu_bsrc = alu_bsrc_i;
               ext_op   = ext_op_i;
               rf_we    = 1'b1;
               pc_we    = 1'b1;
               rf_wsel  = ic.rtype_alu ? WSEL_RD : WSEL_RT;
               wd_sel   = ic.lw ? WD_MEM : WD_ALU;
               state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized
// instruction / mem_rdy streams checked against a per-instruction path model.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, funct;
   logic       zero, mem_rdy;
   logic       pc_we, ir_we, rf_we, alu_bsrc, dm_we, illegal;
   logic [1:0] npcop, rf_wsel, wd_sel, alu_op, ext_op;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .mem_rdy(mem_rdy), .pc_we(pc_we), .npcop(npcop), .ir_we(ir_we),
      .rf_we(rf_we), .rf_wsel(rf_wsel), .wd_sel(wd_sel), .alu_op(alu_op),
      .alu_bsrc(alu_bsrc), .ext_op(ext_op), .dm_we(dm_we),
      .illegal(illegal), .state(state)
   );

   // {pc_we, npcop, ir_we, rf_we, rf_wsel, wd_sel, alu_op, alu_bsrc, ext_op, dm_we, illegal}
   logic [15:0] obs;
   assign obs = {pc_we, npcop, ir_we, rf_we, rf_wsel, wd_sel,
                 alu_op, alu_bsrc, ext_op, dm_we, illegal};

   // Instruction kinds
   localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                  K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9,
                  K_ILLOP = 10, K_ILLFN = 11;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic set_instr(input int k);
      logic [5:0] f;
      f = 6'($urandom);
      case (k)
         K_ADDU:  begin op = 6'h00; funct = 6'h21; end
         K_SUBU:  begin op = 6'h00; funct = 6'h23; end
         K_ORI:   begin op = 6'h0d; funct = f; end
         K_LUI:   begin op = 6'h0f; funct = f; end
         K_LW:    begin op = 6'h23; funct = f; end
         K_SW:    begin op = 6'h2b; funct = f; end
         K_BEQ:   begin op = 6'h04; funct = f; end
         K_J:     begin op = 6'h02; funct = f; end
         K_JAL:   begin op = 6'h03; funct = f; end
         K_JR:    begin op = 6'h00; funct = 6'h08; end
         K_ILLOP: begin op = 6'h3f; funct = f; end
         default: begin
            op = 6'h00;
            while (f == 6'h21 || f == 6'h23 || f == 6'h08) f = 6'($urandom);
            funct = f;
         end
      endcase
   endtask

   // Sequence of states an instruction walks through (ignoring stalls).
   function automatic int path_len(input int k);
      case (k)
         K_LW:                             return 5;
         K_BEQ:                            return 3;
         K_J, K_JAL, K_JR, K_ILLOP, K_ILLFN: return 2;
         default:                          return 4;
      endcase
   endfunction

   function automatic int path_st(input int k, input int p);
      case (p)
         0: return 0;
         1: return 1;
         2: return 2;
         3: return (k == K_LW || k == K_SW) ? 3 : 4;
         default: return 4;
      endcase
   endfunction

   // Expected output vector for instruction k in state st.
   function automatic logic [15:0] exp_out(input int k, input int st, input logic rdy);
      logic       pw, iw, rw, bs, dw, il;
      logic [1:0] np, ws, wd, ao, eo;
      {pw, iw, rw, bs, dw, il} = '0;
      {np, ws, wd, ao, eo} = '0;
      if (st >= 2) begin
         case (k)
            K_SUBU, K_BEQ: ao = 2'b01;
            K_ORI:         begin ao = 2'b10; bs = 1; end
            K_LUI:         begin ao = 2'b11; bs = 1; eo = 2'b10; end
            K_LW, K_SW:    begin bs = 1; eo = 2'b01; end
            default: ;
         endcase
      end
      case (st)
         0: iw = rdy;
         1: case (k)
               K_J:   begin pw = 1; np = 2'b10; end
               K_JAL: begin pw = 1; np = 2'b10; rw = 1; ws = 2'b10; wd = 2'b10; end
               K_JR:  begin pw = 1; np = 2'b11; end
               K_ILLOP, K_ILLFN: begin pw = 1; il = 1; end
               default: ;
            endcase
         2: if (k == K_BEQ) begin pw = 1; np = 2'b01; end
         3: if (k == K_SW) begin dw = rdy; pw = rdy; end
         default: begin
            rw = 1; pw = 1;
            ws = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
            wd = (k == K_LW) ? 2'b01 : 2'b00;
         end
      endcase
      return {pw, np, iw, rw, ws, wd, ao, bs, eo, dw, il};
   endfunction

   // Runs one instruction from FETCH to its last cycle, checking every cycle.
   // rnd=1: random mem_rdy; rnd=0: mem_rdy=1 except mem_waits stalls in MEM.
   // zv<0: random zero, else fixed value.
   task automatic run_instr(input int k, input bit rnd, input int mem_waits, input int zv);
      int  p = 0, cyc = 0, pcw = 0, mw = mem_waits, st;
      bit  rdy;
      set_instr(k);
      while (p < path_len(k) && cyc < 60) begin
         st = path_st(k, p);
         if (rnd) rdy = ($urandom_range(3) != 0);
         else if (st == 3 && mw > 0) begin rdy = 0; mw--; end
         else rdy = 1;
         mem_rdy = rdy;
         zero = (zv < 0) ? 1'($urandom) : 1'(zv);
         @(negedge clk);
         chk($sformatf("state k%0d c%0d", k, cyc), 32'(state), 32'(st));
         chk($sformatf("outs k%0d st%0d c%0d", k, st, cyc), 32'(obs), 32'(exp_out(k, st, rdy)));
         pcw += int'(pc_we);
         if (!((st == 0 || st == 3) && !rdy)) p++;
         @(posedge clk); #1;
         cyc++;
      end
      chk($sformatf("bound k%0d", k), 32'(cyc < 60), 32'd1);
      chk($sformatf("pc_we count k%0d", k), 32'(pcw), 32'd1);
   endtask

   initial begin
      rst = 1; op = 6'h00; funct = 6'h21; zero = 0; mem_rdy = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset state", 32'(state), 32'd0);
      chk("reset outs", 32'(obs), 32'd0);
      @(posedge clk); #1;
      rst = 0;

      // addu, no stalls: states 0,1,2,4
      run_instr(K_ADDU, 0, 0, -1);
      // lw with two stall cycles in MEM: 7 cycles
      run_instr(K_LW, 0, 2, -1);
      // beq with both zero values
      run_instr(K_BEQ, 0, 0, 1);
      run_instr(K_BEQ, 0, 0, 0);
      run_instr(K_JAL, 0, 0, -1);
      run_instr(K_JR, 0, 0, -1);
      run_instr(K_ILLOP, 0, 0, -1);
      run_instr(K_SW, 0, 1, -1);

      // sw interrupted by rst while stalled in MEM
      set_instr(K_SW);
      mem_rdy = 1;
      repeat (3) begin @(posedge clk); #1; end
      mem_rdy = 0;
      @(negedge clk);
      chk("sw stall state", 32'(state), 32'd3);
      chk("sw stall dm_we", 32'(dm_we), 32'd0);
      @(posedge clk); #1;
      rst = 1; mem_rdy = 1;
      @(negedge clk);
      chk("rst in MEM dm_we", 32'(dm_we), 32'd0);
      chk("rst in MEM pc_we", 32'(pc_we), 32'd0);
      @(posedge clk); #1;
      rst = 0; mem_rdy = 0;
      @(negedge clk);
      chk("state after rst", 32'(state), 32'd0);
      chk("no enables after rst", 32'(obs), 32'd0);
      @(posedge clk); #1;

      // randomized instruction stream
      for (int i = 0; i < 80; i++)
         run_instr($urandom_range(11), 1, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS-subset CPU. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB. It drives the write enables and mux selects of the PC, IR, register file, ALU, extender and data memory. It also drives the next-PC unit's `npcop` and is the only source of `pc_we`, so the PC advances exactly once per instruction, in that instruction's final state.

## Interface
Parameters: none; all encodings come from `mc_pkg`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `op` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag; sampled combinationally in EXE.
- `mem_rdy` in 1: memory handshake; the current FETCH/MEM access completes in a cycle with `mem_rdy`=1.
- `pc_we` out 1: PC load.
- `npcop` out 2: 00 pc+4, 01 beq, 10 j/jal, 11 jr.
- `ir_we` out 1: IR load.
- `rf_we` out 1: register file write.
- `rf_wsel` out 2: write address select. 00 rt, 01 rd, 10 $31.
- `wd_sel` out 2: write data select. 00 ALU, 01 memory, 10 pc_4.
- `alu_op` out 2: 00 add, 01 sub, 10 or, 11 lui.
- `alu_bsrc` out 1: ALU B operand. 0 register, 1 extended immediate.
- `ext_op` out 2: 00 zero-extend, 01 sign-extend, 10 imm<<16.
- `dm_we` out 1: data memory write.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `state` out 3: current state, for debug.

## Operation
- Supported instructions:
  - R-type (op 000000) with funct 100001 addu, 100011 subu, 001000 jr.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- FETCH:
  - `ir_we` = `mem_rdy`.
  - Stay in FETCH while `mem_rdy`=0.
  - Go to DECODE when `mem_rdy`=1.
- DECODE:
  - j: `pc_we`=1, `npcop`=10, then FETCH.
  - jal: `pc_we`=1, `npcop`=10, `rf_we`=1, `rf_wsel`=10, `wd_sel`=10, then FETCH.
  - jr: `pc_we`=1, `npcop`=11, then FETCH.
  - Illegal opcode/funct: `illegal`=1, `pc_we`=1, `npcop`=00 (executes as a nop), then FETCH.
  - All others: go to EXE.
- EXE:
  - addu/subu: `alu_op` add/sub, `alu_bsrc`=0, then WB.
  - ori: `alu_op`=or, `alu_bsrc`=1, `ext_op`=00, then WB.
  - lui: `alu_op`=lui, `alu_bsrc`=1, `ext_op`=10, then WB.
  - lw/sw: `alu_op`=add, `alu_bsrc`=1, `ext_op`=01, then MEM.
  - beq: `alu_op`=sub, `pc_we`=1, `npcop`=01, then FETCH. The NPC unit consumes `zero`; the controller does not gate `pc_we` on `zero`.
- MEM:
  - sw: `dm_we` = `mem_rdy`, `pc_we` = `mem_rdy`, `npcop`=00.
  - lw: no enables.
  - Hold in MEM while `mem_rdy`=0. When `mem_rdy`=1: sw goes to FETCH, lw goes to WB.
- WB:
  - `rf_we`=1 and `pc_we`=1 with `npcop`=00, then FETCH.
  - `rf_wsel`: 01 for R-type, 00 for ori/lui/lw.
  - `wd_sel`: 01 for lw, 00 otherwise.
- EXE/MEM selects for the current instruction are held through WB.
- All outputs not listed for a state are 0.
- Unreachable state encodings (5–7) go to FETCH with all outputs 0.

## Timing
- The state register is the only sequential element; outputs are combinational from state, op, funct and `mem_rdy`.
- Reset values:
  - `state`=FETCH.
  - `pc_we`, `ir_we`, `rf_we`, `dm_we`, `illegal` = 0.
  - All selects = 0.
- `rst` asserted in any state: next cycle is FETCH. No enable is asserted in the cycle `rst` is high, so an in-flight sw or lw is dropped.
- Cycles per instruction with `mem_rdy` always 1:
  - j/jal/jr/illegal: 2.
  - beq: 3.
  - R-type/ori/lui/sw: 4.
  - lw: 5.
- Each cycle of `mem_rdy`=0 in FETCH or MEM adds one cycle. No enable fires during those cycles.
- `pc_we` is asserted exactly once per instruction, in that instruction's last cycle. Because the PC is unchanged until then, the NPC's pc+4 and pc_4 refer to the current instruction.

## Structure
- Package `mc_pkg`:
  - State encodings.
  - Opcode and funct constants.
  - `npcop`, `alu_op`, `ext_op`, `rf_wsel` and `wd_sel` encodings.
- Sub-module `mc_decode`: purely combinational. Maps (op, funct) to a one-hot instruction class (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, illegal).
- `mc_ctrl` holds the state register and the per-state output logic.

## Test plan
- Reset, then addu (op 0, funct 100001), `mem_rdy`=1 → states 0,1,2,4. In cycle 4: `rf_we`=1, `rf_wsel`=01, `pc_we`=1, `npcop`=00.
- lw with `mem_rdy` low for 2 cycles in MEM → 7 cycles total. `pc_we` and `rf_we` only in WB, with `wd_sel`=01. No enables during the wait cycles.
- beq, once with `zero`=1 and once with `zero`=0 → 3 cycles each; cycle 3 has `pc_we`=1, `npcop`=01.
- jal → cycle 2: `pc_we`=1, `npcop`=10, `rf_we`=1, `rf_wsel`=10, `wd_sel`=10. jr → cycle 2: `npcop`=11.
- Opcode 111111 → cycle 2: `illegal`=1, `pc_we`=1, `npcop`=00; next state FETCH.
- sw with `rst` asserted while in MEM with `mem_rdy`=0 → `dm_we` and `pc_we` never assert; `state`=0 the cycle after `rst`.
